// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nand4_filt.sv
// Persistence-filtered NAND4: ZN follows the registered NAND term only after THRESH consecutive mismatching cycles.
// Latency THRESH+1 edges from input step to ZN; EN low freezes all state; optional edge pulses under GF180MCU_NAND4_FILT_EDGE_EN.
module gf180mcu_fd_sc_mcu7t5v0__nand4_filt #(
  parameter int CNT_W  = 3,
  parameter int THRESH = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
`ifdef GF180MCU_NAND4_FILT_EDGE_EN
  output logic ZN_RISE,
  output logic ZN_FALL,
`endif
  output logic ZN,
  output logic BUSY
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);

  logic             raw;
  logic             raw_q, raw_d;
  logic             zn_q, zn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    raw   = ~(A1 & A2 & A3 & A4);
    raw_d = raw_q;
    zn_d  = zn_q;
    cnt_d = cnt_q;
    if (EN) begin
      raw_d = raw;
      if (raw_q == zn_q) begin
        cnt_d = '0;
      end else if (cnt_q >= CNT_LAST) begin
        // Mismatch has persisted long enough: commit and restart the count.
        zn_d  = raw_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      raw_q <= 1'b1;
      zn_q  <= 1'b1;
      cnt_q <= '0;
    end else begin
      raw_q <= raw_d;
      zn_q  <= zn_d;
      cnt_q <= cnt_d;
    end
  end

  assign ZN   = zn_q;
  assign BUSY = (cnt_q != '0);

`ifdef GF180MCU_NAND4_FILT_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // zn_d only differs from zn_q on an enabled edge, so EN=0 yields no pulse.
  always_comb begin
    rise_d = EN & zn_d & ~zn_q;
    fall_d = EN & ~zn_d & zn_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign ZN_RISE = rise_q;
  assign ZN_FALL = fall_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nand4_filt.sv
// Bench for the persistence-filtered NAND4: a THRESH=4 and a THRESH=1 instance share stimulus and a reference model.
module tb_gf180mcu_fd_sc_mcu7t5v0__nand4_filt;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] a;  // a[3]=A1 .. a[0]=A4
  logic       zn4, busy4, zn1, busy1;
`ifdef GF180MCU_NAND4_FILT_EDGE_EN
  logic       rise4, fall4, rise1, fall1;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = THRESH 4, index 1 = THRESH 1.
  int   th [2] = '{4, 1};
  logic m_raw [2];
  logic m_zn  [2];
  logic m_rise[2];
  logic m_fall[2];
  int   m_run [2];  // length of the current run of raw samples disagreeing with ZN

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__nand4_filt #(.CNT_W(3), .THRESH(4)) u_dut4 (
    .CLK(clk), .RST(rst), .EN(en),
    .A1(a[3]), .A2(a[2]), .A3(a[1]), .A4(a[0]),
`ifdef GF180MCU_NAND4_FILT_EDGE_EN
    .ZN_RISE(rise4), .ZN_FALL(fall4),
`endif
    .ZN(zn4), .BUSY(busy4)
  );

  gf180mcu_fd_sc_mcu7t5v0__nand4_filt #(.CNT_W(3), .THRESH(1)) u_dut1 (
    .CLK(clk), .RST(rst), .EN(en),
    .A1(a[3]), .A2(a[2]), .A3(a[1]), .A4(a[0]),
`ifdef GF180MCU_NAND4_FILT_EDGE_EN
    .ZN_RISE(rise1), .ZN_FALL(fall1),
`endif
    .ZN(zn1), .BUSY(busy1)
  );

  // Apply one cycle of stimulus, advance the model across the edge, then settle past it.
  task automatic step(input logic r, input logic e, input logic [3:0] av);
    logic prev;
    rst = r;
    en  = e;
    a   = av;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_rise[k] = 1'b0;
      m_fall[k] = 1'b0;
      if (r) begin
        m_raw[k] = 1'b1;
        m_zn[k]  = 1'b1;
        m_run[k] = 0;
      end else if (e) begin
        prev     = m_raw[k];
        m_raw[k] = ~&av;
        if (prev == m_zn[k]) begin
          m_run[k] = 0;
        end else begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == th[k]) begin
            m_rise[k] = prev;
            m_fall[k] = ~prev;
            m_zn[k]   = prev;
            m_run[k]  = 0;
          end
        end
      end
    end
    #1;
  endtask

  // Reset, then let raw_q settle on A=0111 so the filter idles at ZN=1.
  task automatic reset_idle();
    step(1'b1, 1'b1, 4'b1111);
    step(1'b0, 1'b1, 4'b0111);
    step(1'b0, 1'b1, 4'b0111);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step((i < 2), 1'b1, 4'b1111);
      checks++;
      if (zn4 !== 1'b1) begin errors++; $display("FAIL reset_zn cycle %0d: got %b expected 1", i, zn4); end
      checks++;
      if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy cycle %0d: got %b expected 0", i, busy4); end
`ifdef GF180MCU_NAND4_FILT_EDGE_EN
      checks++;
      if ({rise4, fall4} !== 2'b00) begin errors++; $display("FAIL reset_pulse cycle %0d: got %b expected 00", i, {rise4, fall4}); end
`endif
    end
    // raw_q is now 0 against ZN=1; returning to 0111 gives one counted cycle, then clears.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 4'b0111);
      checks++;
      if (busy4 !== (i == 0)) begin errors++; $display("FAIL reset_release_busy cycle %0d: got %b expected %b", i, busy4, (i == 0)); end
    end
  endtask

  task automatic test_glitch();
    reset_idle();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, (i < 3) ? 4'b1111 : 4'b0111);
      checks++;
      if (zn4 !== 1'b1) begin errors++; $display("FAIL glitch_zn edge %0d: got %b expected 1", i, zn4); end
      checks++;
      if (busy4 !== (i >= 1 && i <= 3)) begin errors++; $display("FAIL glitch_busy edge %0d: got %b expected %b", i, busy4, (i >= 1 && i <= 3)); end
`ifdef GF180MCU_NAND4_FILT_EDGE_EN
      checks++;
      if ({rise4, fall4} !== 2'b00) begin errors++; $display("FAIL glitch_pulse edge %0d: got %b expected 00", i, {rise4, fall4}); end
`endif
    end
  endtask

  task automatic test_fall();
    reset_idle();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 4'b1111);
      checks++;
      if (zn4 !== (i < 4)) begin errors++; $display("FAIL fall_zn edge %0d: got %b expected %b", i, zn4, (i < 4)); end
      checks++;
      if (busy4 !== (i >= 1 && i <= 3)) begin errors++; $display("FAIL fall_busy edge %0d: got %b expected %b", i, busy4, (i >= 1 && i <= 3)); end
`ifdef GF180MCU_NAND4_FILT_EDGE_EN
      checks++;
      if ({rise4, fall4} !== {1'b0, (i == 4)}) begin errors++; $display("FAIL fall_pulse edge %0d: got %b expected %b", i, {rise4, fall4}, {1'b0, (i == 4)}); end
`endif
    end
  endtask

  task automatic test_freeze();
    reset_idle();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1111);
    checks++;
    if (busy4 !== 1'b1) begin errors++; $display("FAIL freeze_precount: got %b expected 1", busy4); end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      checks++;
      if ({zn4, busy4} !== 2'b11) begin errors++; $display("FAIL freeze_hold cycle %0d: got %b expected 11", i, {zn4, busy4}); end
`ifdef GF180MCU_NAND4_FILT_EDGE_EN
      checks++;
      if ({rise4, fall4} !== 2'b00) begin errors++; $display("FAIL freeze_pulse cycle %0d: got %b expected 00", i, {rise4, fall4}); end
`endif
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 4'b1111);
      checks++;
      if (zn4 !== (i == 0)) begin errors++; $display("FAIL freeze_resume edge %0d: got %b expected %b", i, zn4, (i == 0)); end
    end
  endtask

  task automatic test_mid_reset();
    reset_idle();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1111);
    step(1'b1, 1'b0, 4'b1111);
    checks++;
    if ({zn4, busy4} !== 2'b10) begin errors++; $display("FAIL midreset_state: got %b expected 10", {zn4, busy4}); end
    step(1'b0, 1'b1, 4'b0111);
    checks++;
    if ({zn4, busy4} !== 2'b10) begin errors++; $display("FAIL midreset_release: got %b expected 10", {zn4, busy4}); end
`ifdef GF180MCU_NAND4_FILT_EDGE_EN
    checks++;
    if ({rise4, fall4} !== 2'b00) begin errors++; $display("FAIL midreset_pulse: got %b expected 00", {rise4, fall4}); end
`endif
  endtask

  task automatic test_thresh1();
    logic       applied[24];
    logic [3:0] av;
    step(1'b1, 1'b1, 4'b1111);
    for (int i = 0; i < 24; i++) begin
      av = (((i / 3) % 2) == 0) ? 4'b1111 : 4'b0111;
      applied[i] = ~&av;
      step(1'b0, 1'b1, av);
      if (i >= 1) begin
        checks++;
        if (zn1 !== applied[i-1]) begin errors++; $display("FAIL thresh1_zn edge %0d: got %b expected %b", i, zn1, applied[i-1]); end
      end
      checks++;
      if (busy1 !== 1'b0) begin errors++; $display("FAIL thresh1_busy edge %0d: got %b expected 0", i, busy1); end
    end
  endtask

  task automatic test_random();
    logic [3:0] av;
    logic       r, e;
    av = 4'b0111;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0)
        av = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : ((av == 4'b1111) ? 4'b0111 : 4'b1111);
      step(r, e, av);
      checks++;
      if ({zn4, busy4} !== {m_zn[0], (m_run[0] != 0)}) begin
        errors++; $display("FAIL random_t4 cycle %0d: got zn,busy=%b expected %b", i, {zn4, busy4}, {m_zn[0], (m_run[0] != 0)});
      end
      checks++;
      if ({zn1, busy1} !== {m_zn[1], (m_run[1] != 0)}) begin
        errors++; $display("FAIL random_t1 cycle %0d: got zn,busy=%b expected %b", i, {zn1, busy1}, {m_zn[1], (m_run[1] != 0)});
      end
`ifdef GF180MCU_NAND4_FILT_EDGE_EN
      checks++;
      if ({rise4, fall4, rise1, fall1} !== {m_rise[0], m_fall[0], m_rise[1], m_fall[1]}) begin
        errors++; $display("FAIL random_pulse cycle %0d: got %b expected %b", i, {rise4, fall4, rise1, fall1}, {m_rise[0], m_fall[0], m_rise[1], m_fall[1]});
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    a   = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      m_raw[k] = 1'b1; m_zn[k] = 1'b1; m_run[k] = 0; m_rise[k] = 1'b0; m_fall[k] = 1'b0;
    end
    test_reset();
    test_glitch();
    test_fall();
    test_freeze();
    test_mid_reset();
    test_thresh1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
